t01_wishbone_manager: RTL and testbench

- Bus master that sits directly downstream of the team 01 request unit and converts its single-cycle read_i/write_i strobes into one classic Wishbone B4 single-beat cycle on the shared memory bus.
- Drives busy_o back to the request unit. On a read, returns cpu_dat_o to it.
- Bounds every bus cycle with a timeout so the CPU cannot hang on an absent slave.

---
 rtl/t01_wb_pkg.sv | 15 +
 rtl/t01_wishbone_manager.sv | 148 ++++++++++++++
 tb/tb_t01_wishbone_manager.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/t01_wb_pkg.sv
// Shared types and constants for the team 01 Wishbone bus manager.
package t01_wb_pkg;

  // DONE is reserved; it exists so an illegal encoding has a defined exit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    BUS   = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

  localparam logic [3:0]  WB_SEL_ALL          = 4'b1111;
  localparam logic [31:0] WB_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/t01_wishbone_manager.sv
// Converts single-cycle read/write strobes from the request unit into one
// classic Wishbone single-beat cycle, with a bounded wait for ACK_I/ERR_I.
module t01_wishbone_manager
  import t01_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = WB_ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] cpu_dat_i,
  input  logic [3:0]  sel_i,
  output logic        busy_o,
  output logic [31:0] cpu_dat_o,
  output logic        bus_err,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I,
  input  logic        ERR_I
);

  wb_state_t   state_q, state_d;
  logic        op_q, op_d;          // 1 = write
  logic [7:0]  cnt_q, cnt_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        timeout;

  // Fires in the BUS cycle in which the count of BUS cycles reaches the limit.
  assign timeout = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

  // Next-state and next-output logic for the request/bus sequencer.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read_i || write_i) begin
          state_d = LATCH;
          op_d    = write_i;
        end
      end
      // Address is only valid one cycle after the strobe, so capture here.
      LATCH: begin
        state_d = BUS;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = op_q;
        adr_d   = adr_i;
        dat_d   = cpu_dat_i;
        sel_d   = sel_i;
        cnt_d   = 8'd0;
      end
      BUS: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (ERR_I || ACK_I || timeout) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          adr_d   = '0;
          dat_d   = '0;
          sel_d   = '0;
          // ERR_I beats ACK_I; a timeout only counts when the slave is silent.
          if (ERR_I || !ACK_I) begin
            err_d = 1'b1;
            if (!op_q) rdata_d = ERR_DATA;
          end else if (!op_q) begin
            rdata_d = DAT_I;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        adr_d   = '0;
        dat_d   = '0;
        sel_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered bus outputs; reset clears the bus asynchronously.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      cnt_q   <= 8'd0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign cpu_dat_o = rdata_q;
  assign bus_err   = err_q;
  assign CYC_O     = cyc_q;
  assign STB_O     = stb_q;
  assign WE_O      = we_q;
  assign ADR_O     = adr_q;
  assign DAT_O     = dat_q;
  assign SEL_O     = sel_q;

endmodule

// File: tb/tb_t01_wishbone_manager.sv
// Bench for t01_wishbone_manager: transaction-timeline model checked every
// cycle, plus literal expectations per directed transaction.
module tb_t01_wishbone_manager;

  localparam int unsigned TO       = 4;
  localparam logic [31:0] ERR_EXP  = 32'hDEAD_BEEF;
  localparam int          K_ACK    = 0;
  localparam int          K_ERR    = 1;
  localparam int          K_ERRACK = 2;
  localparam int          K_SILENT = 3;

  logic        clk = 1'b0;
  logic        nRST;
  logic        read_i, write_i;
  logic [31:0] adr_i, cpu_dat_i;
  logic [3:0]  sel_i;
  logic        busy_o;
  logic [31:0] cpu_dat_o;
  logic        bus_err;
  logic        CYC_O, STB_O, WE_O;
  logic [31:0] ADR_O, DAT_O;
  logic [3:0]  SEL_O;
  logic [31:0] DAT_I;
  logic        ACK_I, ERR_I;

  t01_wishbone_manager #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .nRST     (nRST),
    .read_i   (read_i),
    .write_i  (write_i),
    .adr_i    (adr_i),
    .cpu_dat_i(cpu_dat_i),
    .sel_i    (sel_i),
    .busy_o   (busy_o),
    .cpu_dat_o(cpu_dat_o),
    .bus_err  (bus_err),
    .CYC_O    (CYC_O),
    .STB_O    (STB_O),
    .WE_O     (WE_O),
    .ADR_O    (ADR_O),
    .DAT_O    (DAT_O),
    .SEL_O    (SEL_O),
    .DAT_I    (DAT_I),
    .ACK_I    (ACK_I),
    .ERR_I    (ERR_I)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model outputs for the current cycle.
  logic        chk_en = 1'b0;
  logic        exp_busy, exp_cyc, exp_stb, exp_we, exp_err;
  logic [31:0] exp_adr, exp_dat;
  logic [3:0]  exp_sel;
  logic [31:0] rd_model;

  typedef struct {
    int          busy_cnt;
    int          stb_cnt;
    int          we_cnt;
    int          err_cnt;
    logic [31:0] adr_seen;
    logic [31:0] dat_seen;
    logic [3:0]  sel_seen;
    logic [31:0] cpu_at_fall;
  } obs_t;

  obs_t ob;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: compare DUT outputs against the timeline model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_o", 32'(busy_o), 32'(exp_busy));
      chk("CYC_O", 32'(CYC_O), 32'(exp_cyc));
      chk("STB_O", 32'(STB_O), 32'(exp_stb));
      chk("WE_O", 32'(WE_O), 32'(exp_we));
      chk("ADR_O", ADR_O, exp_adr);
      chk("DAT_O", DAT_O, exp_dat);
      chk("SEL_O", 32'(SEL_O), 32'(exp_sel));
      chk("bus_err", 32'(bus_err), 32'(exp_err));
      chk("cpu_dat_o", cpu_dat_o, rd_model);
    end
  end

  task automatic set_idle_exp();
    exp_busy = 1'b0; exp_cyc = 1'b0; exp_stb = 1'b0; exp_we = 1'b0; exp_err = 1'b0;
    exp_adr  = '0;   exp_dat = '0;   exp_sel = '0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      read_i = 0; write_i = 0; ACK_I = 0; ERR_I = 0;
      set_idle_exp();
    end
  endtask

  // One transaction. Cycle 0 = strobe, 1 = latch, 2..n+1 = bus, n+2 = busy falls.
  task automatic run_txn(input bit op, input logic [31:0] early_adr, input logic [31:0] adr,
                         input logic [31:0] wdat, input logic [3:0] sel, input int w,
                         input int kind, input logic [31:0] rdat, output obs_t o);
    int  n;
    bit  on, last;
    n = (kind == K_SILENT) ? int'(TO) : w + 1;
    o = '{0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0};
    for (int k = 0; k <= n + 2; k++) begin
      @(posedge clk); #1;
      read_i  = (k == 0) && !op;
      write_i = (k == 0) && op;
      if (k == 0) begin
        adr_i = early_adr; cpu_dat_i = 32'h0; sel_i = 4'h0;
      end else if (k == 1) begin
        adr_i = adr; cpu_dat_i = wdat; sel_i = sel;
      end else begin
        adr_i = 32'hFFFF_FFFC; cpu_dat_i = 32'h7777_7777; sel_i = 4'h0;
      end
      on    = (k >= 2) && (k <= n + 1);
      last  = on && (k == w + 2) && (kind != K_SILENT);
      ACK_I = last && (kind == K_ACK || kind == K_ERRACK);
      ERR_I = last && (kind == K_ERR || kind == K_ERRACK);
      DAT_I = last ? rdat : 32'h5A5A_5A5A;
      exp_busy = (k >= 1) && (k <= n + 1);
      exp_cyc  = on;
      exp_stb  = on;
      exp_we   = on && op;
      exp_adr  = on ? adr : 32'h0;
      exp_dat  = on ? wdat : 32'h0;
      exp_sel  = on ? sel : 4'h0;
      exp_err  = (k == n + 2) && (kind != K_ACK);
      if (k == n + 2 && !op) rd_model = (kind == K_ACK) ? rdat : ERR_EXP;
      @(negedge clk);
      if (busy_o) o.busy_cnt++;
      if (WE_O) o.we_cnt++;
      if (bus_err) o.err_cnt++;
      if (STB_O) begin
        o.stb_cnt++;
        if (o.stb_cnt == 1) begin
          o.adr_seen = ADR_O; o.dat_seen = DAT_O; o.sel_seen = SEL_O;
        end
      end
      if (k == n + 2) o.cpu_at_fall = cpu_dat_o;
    end
  endtask

  initial begin
    nRST = 0; read_i = 0; write_i = 0; adr_i = 0; cpu_dat_i = 0; sel_i = 0;
    DAT_I = 0; ACK_I = 0; ERR_I = 0;
    rd_model = '0;
    set_idle_exp();
    #12;
    chk("reset busy_o", 32'(busy_o), 32'd0);
    chk("reset CYC_O", 32'(CYC_O), 32'd0);
    chk("reset cpu_dat_o", cpu_dat_o, 32'd0);
    @(posedge clk); #1 nRST = 1;
    chk_en = 1'b1;
    idle(2);

    // Read, zero wait states.
    run_txn(0, 32'h0, 32'h0000_0100, 32'h0, 4'hF, 0, K_ACK, 32'h1234_5678, ob);
    chk("rd0 busy cycles", 32'(ob.busy_cnt), 32'd2);
    chk("rd0 ADR_O", ob.adr_seen, 32'h0000_0100);
    chk("rd0 SEL_O", 32'(ob.sel_seen), 32'hF);
    chk("rd0 WE cycles", 32'(ob.we_cnt), 32'd0);
    chk("rd0 cpu_dat_o", ob.cpu_at_fall, 32'h1234_5678);
    idle(1);

    // Write, three wait states.
    run_txn(1, 32'h0, 32'h0000_0200, 32'hCAFE_F00D, 4'hF, 3, K_ACK, 32'h0, ob);
    chk("wr3 STB cycles", 32'(ob.stb_cnt), 32'd4);
    chk("wr3 WE cycles", 32'(ob.we_cnt), 32'd4);
    chk("wr3 busy cycles", 32'(ob.busy_cnt), 32'd5);
    chk("wr3 DAT_O", ob.dat_seen, 32'hCAFE_F00D);
    chk("wr3 cpu_dat_o kept", ob.cpu_at_fall, 32'h1234_5678);

    // Address arrives one cycle late; back-to-back with previous transaction.
    run_txn(0, 32'h0, 32'h0000_0040, 32'h0, 4'h3, 1, K_ACK, 32'h0BAD_F00D, ob);
    chk("ins ADR_O", ob.adr_seen, 32'h0000_0040);
    chk("ins cpu_dat_o", ob.cpu_at_fall, 32'h0BAD_F00D);
    idle(1);

    // Error together with ACK: error wins.
    run_txn(0, 32'h0, 32'h0000_0300, 32'h0, 4'hF, 0, K_ERRACK, 32'h1111_2222, ob);
    chk("err cpu_dat_o", ob.cpu_at_fall, 32'hDEAD_BEEF);
    chk("err pulse cycles", 32'(ob.err_cnt), 32'd1);

    // Write ending in error leaves read data alone.
    run_txn(1, 32'h0, 32'h0000_0304, 32'h0102_0304, 4'h1, 2, K_ERR, 32'h0, ob);
    chk("werr cpu_dat_o kept", ob.cpu_at_fall, 32'hDEAD_BEEF);
    chk("werr pulse cycles", 32'(ob.err_cnt), 32'd1);
    idle(1);

    // Silent slave -> timeout.
    run_txn(0, 32'h0, 32'h0000_0500, 32'h0, 4'hF, 0, K_SILENT, 32'h0, ob);
    chk("to STB cycles", 32'(ob.stb_cnt), 32'd4);
    chk("to busy cycles", 32'(ob.busy_cnt), 32'd5);
    chk("to pulse cycles", 32'(ob.err_cnt), 32'd1);
    chk("to cpu_dat_o", ob.cpu_at_fall, 32'hDEAD_BEEF);
    // Next request after timeout, ACK on the last allowed cycle.
    run_txn(0, 32'h0, 32'h0000_0600, 32'h0, 4'hF, 3, K_ACK, 32'h1357_9BDF, ob);
    chk("post-to cpu_dat_o", ob.cpu_at_fall, 32'h1357_9BDF);
    chk("post-to pulse cycles", 32'(ob.err_cnt), 32'd0);
    idle(1);

    // Reset while in BUS.
    chk_en = 1'b0;
    @(posedge clk); #1;
    read_i = 1; adr_i = 32'h0;
    @(posedge clk); #1;
    read_i = 0; adr_i = 32'h0000_0700; sel_i = 4'hF;
    @(posedge clk); #1;
    adr_i = 32'h0;
    @(negedge clk);
    chk("rst pre CYC_O", 32'(CYC_O), 32'd1);
    #2 nRST = 0;
    #1;
    chk("rst CYC_O", 32'(CYC_O), 32'd0);
    chk("rst STB_O", 32'(STB_O), 32'd0);
    chk("rst busy_o", 32'(busy_o), 32'd0);
    chk("rst ADR_O", ADR_O, 32'd0);
    chk("rst SEL_O", 32'(SEL_O), 32'd0);
    chk("rst cpu_dat_o", cpu_dat_o, 32'd0);
    @(posedge clk); #3 nRST = 1;
    rd_model = '0;
    set_idle_exp();
    chk_en = 1'b1;
    run_txn(0, 32'h0, 32'h0000_0800, 32'h0, 4'hC, 0, K_ACK, 32'h2468_ACE0, ob);
    chk("post-rst ADR_O", ob.adr_seen, 32'h0000_0800);
    chk("post-rst cpu_dat_o", ob.cpu_at_fall, 32'h2468_ACE0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
